// File: rtl/calc_pkg.sv
// Shared keypad/calculator definitions.
// Opcode encodings and handshake state type.
package calc_pkg;

  localparam logic [2:0] OP_NUM = 3'd0;
  localparam logic [2:0] OP_DIV = 3'd1;
  localparam logic [2:0] OP_ENT = 3'd2;
  localparam logic [2:0] OP_CLR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_ADD = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/tok_fifo.sv
// Show-ahead token FIFO with push, pop, flush and level.
// Flush with push leaves exactly the pushed entry.
module tok_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NUM_W = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             flush,
  input  logic [NUM_W-1:0] din_num,
  input  logic [2:0]       din_op,
  input  logic             tok_ready,
  output logic             tok_valid,
  output logic [NUM_W-1:0] tok_num,
  output logic [2:0]       tok_op,
  output logic [LW-1:0]    level
);

  logic [NUM_W-1:0] mem_num [DEPTH];
  logic [2:0]       mem_op  [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign full      = (cnt == LW'(DEPTH));
  assign tok_valid = (cnt != '0);
  assign pop       = tok_valid && tok_ready;
  assign push_ok   = push && !full;
  assign level     = cnt;
  assign tok_num   = tok_valid ? mem_num[rd_ptr] : '0;
  assign tok_op    = tok_valid ? mem_op[rd_ptr]  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_num[i] <= '0;
        mem_op[i]  <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      if (push) begin
        mem_num[0] <= din_num;
        mem_op[0]  <= din_op;
        wr_ptr     <= PW'(1);
        cnt        <= LW'(1);
      end else begin
        wr_ptr <= '0;
        cnt    <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_num[wr_ptr] <= din_num;
        mem_op[wr_ptr]  <= din_op;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/key_token_rx.sv
// Four-phase req/ack token receiver feeding a show-ahead FIFO.
// CLR flushes pending keys; reserved opcode is acked and dropped.
module key_token_rx
  import calc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NUM_W = 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [NUM_W-1:0] num,
  input  logic [2:0]       op,
  output logic             ack,
  output logic             tok_valid,
  output logic [NUM_W-1:0] tok_num,
  output logic [2:0]       tok_op,
  input  logic             tok_ready,
  output logic [LW-1:0]    level,
  output logic             drop
);

  hs_state_t state;
  hs_state_t state_nx;
  logic      cap;
  logic      full;
  logic      rsv;
  logic      push;
  logic      flush;
  logic      drop_q;

  assign full  = (level == LW'(DEPTH));
  assign rsv   = (op == OP_RSV);
  assign push  = cap && !rsv;
  assign flush = cap && (op == OP_CLR);
  assign ack   = (state == S_ACK);
  assign drop  = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nx;
      drop_q <= cap && rsv;
    end
  end

  // Full FIFO stalls every opcode, including CLR and reserved.
  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req && !full) begin
          cap      = 1'b1;
          state_nx = S_ACK;
        end
      end
      S_ACK: begin
        if (!req) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  tok_fifo #(
    .DEPTH(DEPTH),
    .NUM_W(NUM_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .flush    (flush),
    .din_num  (num),
    .din_op   (op),
    .tok_ready(tok_ready),
    .tok_valid(tok_valid),
    .tok_num  (tok_num),
    .tok_op   (tok_op),
    .level    (level)
  );

endmodule

// File: tb/tb_key_token_rx.sv
// Directed bench for key_token_rx.
// Inputs change 1ns after posedge; outputs checked there too.
module tb_key_token_rx;

  localparam int DEPTH = 4;
  localparam int NUM_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic [NUM_W-1:0] num = '0;
  logic [2:0]       op = '0;
  logic             ack;
  logic             tok_valid;
  logic [NUM_W-1:0] tok_num;
  logic [2:0]       tok_op;
  logic             tok_ready = 1'b0;
  logic [2:0]       level;
  logic             drop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  key_token_rx #(.DEPTH(DEPTH), .NUM_W(NUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .num(num), .op(op),
    .ack(ack), .tok_valid(tok_valid), .tok_num(tok_num),
    .tok_op(tok_op), .tok_ready(tok_ready), .level(level),
    .drop(drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full two-cycle handshake; no checking here.
  task automatic send(input logic [7:0] n, input logic [2:0] o);
    req = 1'b1; num = n; op = o;
    step();
    req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++;
    if ({ack, tok_valid, level, tok_num, tok_op, drop} !== '0) begin
      fails++;
      $display("FAIL reset: ack=%b v=%b lvl=%0d num=%0d op=%0d drop=%b want all 0",
               ack, tok_valid, level, tok_num, tok_op, drop);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    req = 1'b1; num = 8'd5; op = 3'd0;
    step();
    tests++;
    if (ack !== 1'b1 || level !== 3'd1 || tok_valid !== 1'b1 || tok_num !== 8'd5) begin
      fails++;
      $display("FAIL basic_cap: ack=%b lvl=%0d v=%b num=%0d want 1 1 1 5",
               ack, level, tok_valid, tok_num);
    end
    req = 1'b0;
    step();
    tests++;
    if (ack !== 1'b0) begin
      fails++;
      $display("FAIL basic_release: ack=%b want 0", ack);
    end
    tok_ready = 1'b1;
    step();
    tok_ready = 1'b0;
    tests++;
    if (level !== 3'd0 || tok_valid !== 1'b0 || tok_num !== 8'd0 || tok_op !== 3'd0) begin
      fails++;
      $display("FAIL basic_pop: lvl=%0d v=%b num=%0d op=%0d want 0 0 0 0",
               level, tok_valid, tok_num, tok_op);
    end
  endtask

  task automatic test_full();
    logic [7:0] exp_n [4];
    logic [2:0] exp_o [4];
    exp_n = '{8'd2, 8'd3, 8'd4, 8'd9};
    exp_o = '{3'd0, 3'd0, 3'd0, 3'd6};
    tok_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 3'd0);
    tests++;
    if (level !== 3'd4) begin
      fails++;
      $display("FAIL full_level: lvl=%0d want 4", level);
    end
    req = 1'b1; num = 8'd9; op = 3'd6;
    step();
    step();
    tests++;
    if (ack !== 1'b0 || level !== 3'd4) begin
      fails++;
      $display("FAIL full_stall: ack=%b lvl=%0d want 0 4", ack, level);
    end
    tok_ready = 1'b1;
    step();
    tok_ready = 1'b0;
    tests++;
    if (ack !== 1'b0 || level !== 3'd3 || tok_num !== 8'd2) begin
      fails++;
      $display("FAIL full_pop: ack=%b lvl=%0d num=%0d want 0 3 2", ack, level, tok_num);
    end
    step();
    tests++;
    if (ack !== 1'b1 || level !== 3'd4) begin
      fails++;
      $display("FAIL full_resume: ack=%b lvl=%0d want 1 4", ack, level);
    end
    req = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (tok_valid !== 1'b1 || tok_num !== exp_n[i] || tok_op !== exp_o[i]) begin
        fails++;
        $display("FAIL full_drain%0d: v=%b num=%0d op=%0d want 1 %0d %0d",
                 i, tok_valid, tok_num, tok_op, exp_n[i], exp_o[i]);
      end
      tok_ready = 1'b1;
      step();
      tok_ready = 1'b0;
    end
    tests++;
    if (level !== 3'd0 || tok_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_empty: lvl=%0d v=%b want 0 0", level, tok_valid);
    end
  endtask

  task automatic test_clr();
    tok_ready = 1'b0;
    send(8'd7, 3'd0);
    send(8'd8, 3'd4);
    send(8'd9, 3'd0);
    tests++;
    if (level !== 3'd3) begin
      fails++;
      $display("FAIL clr_pre: lvl=%0d want 3", level);
    end
    tok_ready = 1'b1;
    req = 1'b1; num = 8'd0; op = 3'd3;
    step();
    tok_ready = 1'b0;
    tests++;
    if (level !== 3'd1 || tok_op !== 3'd3 || tok_num !== 8'd0 || ack !== 1'b1) begin
      fails++;
      $display("FAIL clr_cap: lvl=%0d op=%0d num=%0d ack=%b want 1 3 0 1",
               level, tok_op, tok_num, ack);
    end
    req = 1'b0;
    step();
    tok_ready = 1'b1;
    step();
    tok_ready = 1'b0;
    tests++;
    if (level !== 3'd0) begin
      fails++;
      $display("FAIL clr_drain: lvl=%0d want 0", level);
    end
  endtask

  task automatic test_drop();
    send(8'd1, 3'd2);
    req = 1'b1; num = 8'd3; op = 3'd7;
    step();
    tests++;
    if (ack !== 1'b1 || drop !== 1'b1 || level !== 3'd1) begin
      fails++;
      $display("FAIL drop_cap: ack=%b drop=%b lvl=%0d want 1 1 1", ack, drop, level);
    end
    req = 1'b0;
    step();
    tests++;
    if (ack !== 1'b0 || drop !== 1'b0 || level !== 3'd1 || tok_op !== 3'd2) begin
      fails++;
      $display("FAIL drop_end: ack=%b drop=%b lvl=%0d op=%0d want 0 0 1 2",
               ack, drop, level, tok_op);
    end
    tok_ready = 1'b1;
    step();
    tok_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    send(8'd10, 3'd0);
    send(8'd11, 3'd0);
    for (int k = 2; k < DEPTH + 3; k++) begin
      tests++;
      if (tok_num !== 8'(10 + k - 2) || level !== 3'd2) begin
        fails++;
        $display("FAIL b2b_head%0d: num=%0d lvl=%0d want %0d 2",
                 k, tok_num, level, 10 + k - 2);
      end
      req = 1'b1; num = 8'(10 + k); op = 3'd0;
      tok_ready = 1'b1;
      step();
      tok_ready = 1'b0;
      tests++;
      if (level !== 3'd2 || ack !== 1'b1) begin
        fails++;
        $display("FAIL b2b_level%0d: lvl=%0d ack=%b want 2 1", k, level, ack);
      end
      req = 1'b0;
      step();
    end
    for (int k = DEPTH + 1; k < DEPTH + 3; k++) begin
      tests++;
      if (tok_num !== 8'(10 + k)) begin
        fails++;
        $display("FAIL b2b_tail%0d: num=%0d want %0d", k, tok_num, 10 + k);
      end
      tok_ready = 1'b1;
      step();
      tok_ready = 1'b0;
    end
    tests++;
    if (level !== 3'd0) begin
      fails++;
      $display("FAIL b2b_empty: lvl=%0d want 0", level);
    end
  endtask

  task automatic test_reset_mid();
    send(8'd20, 3'd0);
    req = 1'b1; num = 8'd21; op = 3'd0;
    step();
    tests++;
    if (ack !== 1'b1 || level !== 3'd2) begin
      fails++;
      $display("FAIL rmid_pre: ack=%b lvl=%0d want 1 2", ack, level);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (ack !== 1'b0 || tok_valid !== 1'b0 || level !== 3'd0) begin
      fails++;
      $display("FAIL rmid_async: ack=%b v=%b lvl=%0d want 0 0 0", ack, tok_valid, level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests++;
    if (ack !== 1'b1 || level !== 3'd1 || tok_num !== 8'd21) begin
      fails++;
      $display("FAIL rmid_recap: ack=%b lvl=%0d num=%0d want 1 1 21", ack, level, tok_num);
    end
    step();
    tests++;
    if (ack !== 1'b1 || level !== 3'd1) begin
      fails++;
      $display("FAIL rmid_hold: ack=%b lvl=%0d want 1 1", ack, level);
    end
    req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_clr();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_token_rx.md
# key_token_rx

Responder end of the keypad token handshake: a four-phase req/ack receiver that accepts `num`/`op` tokens from the key encoder (`in`), buffers them in a small FIFO, and presents them to a downstream consumer on a valid/ready port. It sits between `in` and the calculator core, so the encoder is released as soon as a token is buffered, not when the core finishes. A CLR token also flushes any stale pending keys.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `NUM_W`, 8: token digit width.
- `clk`  input  1  system clock; all logic on posedge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `req`  input  1  token request from the encoder (its `stop`); high = `num`/`op` valid and stable.
- `num`  input  NUM_W  digit value; meaningful when `op` = OP_NUM.
- `op`  input  3  opcode: 0 digit, 1 DIV, 2 ENT, 3 CLR, 4 MUL, 5 SUB, 6 ADD; 7 reserved.
- `ack`  output  1  acknowledge to the encoder (its `start`).
- `tok_valid`  output  1  head token available.
- `tok_num`  output  NUM_W  head token digit.
- `tok_op`  output  3  head token opcode.
- `tok_ready`  input  1  consumer pops head when high with `tok_valid`.
- `level`  output  $clog2(DEPTH)+1  entries held.
- `drop`  output  1  one-cycle pulse: reserved opcode 7 received and discarded.

## Operation
- Handshake FSM, two states:
  - S_IDLE (`ack`=0): if `req`=1 and `level`<DEPTH, capture `num`/`op`, enqueue, go to S_ACK. If `req`=1 and the FIFO is full, stay in S_IDLE with `ack`=0 until space frees.
  - S_ACK (`ack`=1): wait for `req`=0, then go to S_IDLE. `req` held high never causes a second capture.
- Opcode 7: handshake completes normally, nothing enqueued, `drop` pulses on the capture cycle.
- CLR (op 3) capture: all entries flushed, including one popped on the same cycle. CLR is written as the sole entry, so `level`=1 next cycle. The full-FIFO stall applies to CLR too.
- FIFO:
  - Show-ahead: `tok_num`/`tok_op` reflect the head whenever `tok_valid`=1, and are 0 when empty.
  - Pop when `tok_valid && tok_ready`. Pop while empty is ignored.
  - Push and pop in the same cycle (non-CLR) leave `level` unchanged.
  - Pointers wrap modulo DEPTH.
  - No bypass: a token is visible on the cycle after capture at the earliest.
- `tok_valid` = (`level` != 0). It is registered or derived from the registered `level`.
- Reset mid-handshake: `ack` drops immediately, FSM goes to S_IDLE, FIFO empties. An encoder still holding `req` high is captured again after reset deassertion. This is accepted behaviour.

## Timing
- Reset values: `ack`=0, `tok_valid`=0, `tok_num`=0, `tok_op`=0, `level`=0, `drop`=0, state S_IDLE.
- `req` rising, with space available, is sampled at edge N. At edge N:
  - `ack`=1
  - entry written, `level` incremented
  - `tok_valid`=1 if the FIFO was empty.
- `req` falling is sampled at edge M; `ack`=0 after edge M. The earliest next capture is edge M+1.
- The minimum full token cycle is 2 clocks.
- Pop at edge P: the next head appears after edge P, or outputs zero if the FIFO became empty.
- `ack` is registered and never combinational from `req`.

## Structure
- Shared package `calc_pkg`:
  - opcode constants OP_NUM=0, OP_DIV=1, OP_ENT=2, OP_CLR=3, OP_MUL=4, OP_SUB=5, OP_ADD=6
  - state typedef for S_IDLE/S_ACK
  - `calc` and `in` use the same package.
- Sub-module `tok_fifo`:
  - synchronous show-ahead FIFO with push, pop, flush and level
  - flush and push in the same cycle yields exactly the pushed entry.
- The top module holds only the handshake FSM, the opcode screen and the `drop` pulse.

## Test plan
- Reset, then `req`=1 with `num`=5, `op`=0 → next edge `ack`=1, `level`=1, `tok_valid`=1, `tok_num`=5. `req`=0 → `ack`=0 one edge later.
- `tok_ready`=0 and four digit tokens 1,2,3,4 pushed → `level`=4. Fifth token (`op`=6) with `req`=1 → `ack` stays 0. Pop one → `ack` rises on the next edge, and the FIFO drains as 2,3,4, then ADD.
- Three entries buffered, then a CLR token while `tok_ready`=1 → after capture `level`=1, head `tok_op`=3, `tok_num`=0.
- `op`=7 token → `ack` handshake completes, `drop` pulses for one cycle, `level` unchanged.
- Back-to-back push and pop with `level`=2 → `level` stays 2 and order is preserved across pointer wrap (DEPTH+3 tokens total).
- `rst_n` asserted while `ack`=1 with 2 entries → `ack`, `tok_valid` and `level` are 0 immediately (asynchronously). After release with `req` still high → one new capture and `level`=1.
